// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits
// sharing one BCD decoder; display updates are deferred to frame boundaries.
module bcd_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 50000,
    parameter int GAP        = 2,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    RST,
    input  logic                    ENABLE,
    input  logic                    LZ_BLANK,
    input  logic                    WR_VALID,
    input  logic [4*NUM_DIGITS-1:0] WR_DATA,
    output logic                    WR_READY,
    output logic [3:0]              BCD_OUT,
    output logic [NUM_DIGITS-1:0]   DIG_EN_N,
    output logic [IDX_W-1:0]        DIGIT_IDX,
    output logic                    FRAME_DONE
);

    localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHOW = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    logic [1:0]            state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg, idx_next, disp_idx;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [3:0]            active_reg [NUM_DIGITS];
    logic [3:0]            active_next [NUM_DIGITS];
    logic [3:0]            shadow_reg [NUM_DIGITS];
    logic [3:0]            shadow_next [NUM_DIGITS];
    logic [3:0]            wr_words [NUM_DIGITS];
    logic                  pending_reg, pending_next;
    logic                  wr_ready_reg, wr_ready_next;
    logic                  frame_done_reg, frame_done_next;
    logic [3:0]            bcd_reg, bcd_next;
    logic [NUM_DIGITS-1:0] en_reg, en_next;
    logic [NUM_DIGITS-1:0] suppress;
    logic                  wr_fire, seg_end, apply, zeros_above;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
        assign wr_words[gi] = WR_DATA[4*gi +: 4];
    end

    assign wr_fire = WR_VALID && wr_ready_reg;

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        cnt_next        = cnt_reg;
        active_next     = active_reg;
        shadow_next     = shadow_reg;
        pending_next    = pending_reg;
        frame_done_next = 1'b0;
        apply           = 1'b0;
        seg_end         = (state_reg == S_GAP) ? (cnt_reg == GAP_END) : (cnt_reg == DWELL_END);

        if (state_reg == S_IDLE) begin
            idx_next = '0;
            cnt_next = '0;
            if (wr_fire)
                active_next = wr_words;
            if (ENABLE)
                state_next = S_SHOW;
        end else if (!ENABLE) begin
            state_next = S_IDLE;
            idx_next   = '0;
            cnt_next   = '0;
            if (pending_reg) begin
                active_next  = shadow_reg;
                pending_next = 1'b0;
                apply        = 1'b1;
            end
            // Leaving the scan means no frame can tear, so a same-cycle write lands directly.
            if (wr_fire)
                active_next = wr_words;
        end else begin
            if (!seg_end) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end else begin
                cnt_next = '0;
                if (state_reg == S_SHOW && GAP > 0) begin
                    state_next = S_GAP;
                end else begin
                    state_next = S_SHOW;
                    idx_next   = wrap_inc(idx_reg);
                    if (idx_reg == LAST_IDX) begin
                        frame_done_next = 1'b1;
                        if (pending_reg) begin
                            active_next  = shadow_reg;
                            pending_next = 1'b0;
                            apply        = 1'b1;
                        end
                    end
                end
            end
            // Boundary is resolved above, so a write here always waits for the next frame.
            if (wr_fire) begin
                shadow_next  = wr_words;
                pending_next = 1'b1;
            end
        end

        wr_ready_next = !pending_next && !apply;
    end

    always_comb begin
        zeros_above = 1'b1;
        suppress    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeros_above = zeros_above && (active_next[i] == 4'd0);
            suppress[i] = (active_next[i] > 4'd9) || (LZ_BLANK && (i != 0) && zeros_above);
        end
    end

    // During GAP the decoder is precharged with the digit about to be lit.
    always_comb begin
        disp_idx = (state_next == S_GAP) ? wrap_inc(idx_next) : idx_next;
        bcd_next = (state_next == S_IDLE) ? 4'd0 : active_next[disp_idx];
        en_next  = '1;
        if (state_next == S_SHOW && !suppress[idx_next])
            en_next[idx_next] = 1'b0;
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            pending_reg    <= 1'b0;
            wr_ready_reg   <= 1'b1;
            frame_done_reg <= 1'b0;
            bcd_reg        <= 4'd0;
            en_reg         <= '1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_reg[i] <= 4'd0;
                shadow_reg[i] <= 4'd0;
            end
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            pending_reg    <= pending_next;
            wr_ready_reg   <= wr_ready_next;
            frame_done_reg <= frame_done_next;
            bcd_reg        <= bcd_next;
            en_reg         <= en_next;
            active_reg     <= active_next;
            shadow_reg     <= shadow_next;
        end
    end

    assign WR_READY   = wr_ready_reg;
    assign BCD_OUT    = bcd_reg;
    assign DIG_EN_N   = en_reg;
    assign DIGIT_IDX  = idx_reg;
    assign FRAME_DONE = frame_done_reg;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl with a 4-digit bank, DWELL=4 and GAP=1 (20-cycle frame).
module tb_bcd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        lz_blank = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic        wr_ready;
    logic [3:0]  bcd_out;
    logic [3:0]  dig_en_n;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] cap_en  [64];
    logic [3:0] cap_bcd [64];
    logic [1:0] cap_idx [64];
    logic       cap_fd  [64];
    logic       cap_rdy [64];

    bcd_scan_ctrl #(.NUM_DIGITS(4), .DWELL(4), .GAP(1)) dut (
        .CLOCK_50  (clk),
        .RST       (rst),
        .ENABLE    (enable),
        .LZ_BLANK  (lz_blank),
        .WR_VALID  (wr_valid),
        .WR_DATA   (wr_data),
        .WR_READY  (wr_ready),
        .BCD_OUT   (bcd_out),
        .DIG_EN_N  (dig_en_n),
        .DIGIT_IDX (digit_idx),
        .FRAME_DONE(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] nib(input logic [15:0] w, input int d);
        return w[4*d +: 4];
    endfunction

    task automatic do_reset();
        enable   = 1'b0;
        wr_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
    endtask

    task automatic write_word(input logic [15:0] w);
        wr_data  = w;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Returns at the negedge inside the first SHOW cycle of digit 0.
    task automatic start_scan();
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_en[i]  = dig_en_n;
            cap_bcd[i] = bcd_out;
            cap_idx[i] = digit_idx;
            cap_fd[i]  = frame_done;
            cap_rdy[i] = wr_ready;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (dig_en_n !== 4'hF) begin n_fail++; $display("FAIL reset en: got %b want 1111", dig_en_n); end
        n_checks++; if (bcd_out !== 4'h0) begin n_fail++; $display("FAIL reset bcd: got %h want 0", bcd_out); end
        n_checks++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL reset idx: got %0d want 0", digit_idx); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset wr_ready: got %b want 1", wr_ready); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (dig_en_n !== 4'hF) begin n_fail++; $display("FAIL idle en: got %b want 1111", dig_en_n); end
    endtask

    task automatic test_scan();
        int d, k;
        logic [3:0] e_en, e_bcd;
        do_reset();
        write_word(16'h1234);
        start_scan();
        capture(40);
        for (int c = 0; c < 40; c++) begin
            d = (c % 20) / 5;
            k = c % 5;
            e_en  = (k < 4) ? ~(4'b0001 << d) : 4'hF;
            e_bcd = (k < 4) ? nib(16'h1234, d) : nib(16'h1234, (d + 1) % 4);
            n_checks++; if (cap_en[c] !== e_en) begin n_fail++; $display("FAIL scan en c=%0d: got %b want %b", c, cap_en[c], e_en); end
            n_checks++; if (cap_bcd[c] !== e_bcd) begin n_fail++; $display("FAIL scan bcd c=%0d: got %h want %h", c, cap_bcd[c], e_bcd); end
            n_checks++; if (cap_idx[c] !== 2'(d)) begin n_fail++; $display("FAIL scan idx c=%0d: got %0d want %0d", c, cap_idx[c], d); end
            n_checks++; if (cap_fd[c] !== (c == 20)) begin n_fail++; $display("FAIL scan frame_done c=%0d: got %b want %b", c, cap_fd[c], (c == 20)); end
        end
        $display("scan 1234: 40 cycles checked");
    endtask

    task automatic test_update();
        int c, d, k;
        logic [15:0] w;
        logic [3:0] e_en, e_bcd;
        do_reset();
        write_word(16'h1234);
        start_scan();
        repeat (7) @(negedge clk);
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL update ready_before: got %b want 1", wr_ready); end
        wr_data  = 16'h5678;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL update ready_after: got %b want 0", wr_ready); end
        repeat (2) @(negedge clk);
        wr_data  = 16'h9999;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        capture(29);
        for (int i = 0; i < 29; i++) begin
            c = 11 + i;
            d = (c % 20) / 5;
            k = c % 5;
            w = (c < 20) ? 16'h1234 : 16'h5678;
            e_en  = (k < 4) ? ~(4'b0001 << d) : 4'hF;
            e_bcd = (k < 4) ? nib(w, d) : nib(w, (d + 1) % 4);
            n_checks++; if (cap_en[i] !== e_en) begin n_fail++; $display("FAIL update en c=%0d: got %b want %b", c, cap_en[i], e_en); end
            n_checks++; if (cap_bcd[i] !== e_bcd) begin n_fail++; $display("FAIL update bcd c=%0d: got %h want %h", c, cap_bcd[i], e_bcd); end
            n_checks++; if (cap_fd[i] !== (c == 20)) begin n_fail++; $display("FAIL update frame_done c=%0d: got %b want %b", c, cap_fd[i], (c == 20)); end
            n_checks++; if (cap_rdy[i] !== (c >= 21)) begin n_fail++; $display("FAIL update wr_ready c=%0d: got %b want %b", c, cap_rdy[i], (c >= 21)); end
        end
        $display("update 1234->5678 mid-frame: applied at boundary");
    endtask

    task automatic test_lz_blank();
        logic [15:0] words [3] = '{16'h0050, 16'h0000, 16'h1000};
        logic        lzs   [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0]  masks [3] = '{4'b0011, 4'b0001, 4'b1111};
        int d, k;
        logic [3:0] e_en, e_bcd;
        for (int s = 0; s < 3; s++) begin
            do_reset();
            lz_blank = lzs[s];
            write_word(words[s]);
            start_scan();
            capture(20);
            for (int c = 0; c < 20; c++) begin
                d = c / 5;
                k = c % 5;
                e_en  = (k < 4 && masks[s][d]) ? ~(4'b0001 << d) : 4'hF;
                e_bcd = (k < 4) ? nib(words[s], d) : nib(words[s], (d + 1) % 4);
                n_checks++; if (cap_en[c] !== e_en) begin n_fail++; $display("FAIL lz en w=%h c=%0d: got %b want %b", words[s], c, cap_en[c], e_en); end
                n_checks++; if (cap_bcd[c] !== e_bcd) begin n_fail++; $display("FAIL lz bcd w=%h c=%0d: got %h want %h", words[s], c, cap_bcd[c], e_bcd); end
            end
            $display("lz_blank=%b word %h: 20 cycles checked", lzs[s], words[s]);
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_invalid();
        int d, k;
        logic [3:0] e_en, e_bcd;
        do_reset();
        write_word(16'h12A4);
        start_scan();
        capture(40);
        for (int c = 0; c < 40; c++) begin
            d = (c % 20) / 5;
            k = c % 5;
            e_en  = (k < 4 && d != 1) ? ~(4'b0001 << d) : 4'hF;
            e_bcd = (k < 4) ? nib(16'h12A4, d) : nib(16'h12A4, (d + 1) % 4);
            n_checks++; if (cap_en[c] !== e_en) begin n_fail++; $display("FAIL invalid en c=%0d: got %b want %b", c, cap_en[c], e_en); end
            n_checks++; if (cap_bcd[c] !== e_bcd) begin n_fail++; $display("FAIL invalid bcd c=%0d: got %h want %h", c, cap_bcd[c], e_bcd); end
            n_checks++; if (cap_fd[c] !== (c == 20)) begin n_fail++; $display("FAIL invalid frame_done c=%0d: got %b want %b", c, cap_fd[c], (c == 20)); end
        end
        $display("invalid nibble 12A4: digit 1 suppressed");
    endtask

    task automatic test_reset_mid();
        int d, k;
        logic [3:0] e_en;
        do_reset();
        write_word(16'h1234);
        start_scan();
        repeat (7) @(negedge clk);
        wr_data  = 16'h5678;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid pending ready: got %b want 0", wr_ready); end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (dig_en_n !== 4'hF) begin n_fail++; $display("FAIL rstmid en: got %b want 1111", dig_en_n); end
        n_checks++; if (bcd_out !== 4'h0) begin n_fail++; $display("FAIL rstmid bcd: got %h want 0", bcd_out); end
        n_checks++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL rstmid idx: got %0d want 0", digit_idx); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rstmid frame_done: got %b want 0", frame_done); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid wr_ready: got %b want 1", wr_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        capture(25);
        for (int c = 0; c < 25; c++) begin
            d = (c % 20) / 5;
            k = c % 5;
            e_en = (k < 4) ? ~(4'b0001 << d) : 4'hF;
            n_checks++; if (cap_en[c] !== e_en) begin n_fail++; $display("FAIL rstmid scan en c=%0d: got %b want %b", c, cap_en[c], e_en); end
            n_checks++; if (cap_bcd[c] !== 4'h0) begin n_fail++; $display("FAIL rstmid scan bcd c=%0d: got %h want 0", c, cap_bcd[c]); end
            n_checks++; if (cap_fd[c] !== (c == 20)) begin n_fail++; $display("FAIL rstmid frame_done c=%0d: got %b want %b", c, cap_fd[c], (c == 20)); end
        end
        $display("reset mid-scan: restart from zero, pending write lost");
    endtask

    task automatic test_enable_drop();
        do_reset();
        write_word(16'h1234);
        start_scan();
        repeat (7) @(negedge clk);
        wr_data  = 16'h5678;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        n_checks++; if (dig_en_n !== 4'hF) begin n_fail++; $display("FAIL drop en: got %b want 1111", dig_en_n); end
        n_checks++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL drop idx: got %0d want 0", digit_idx); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL drop frame_done: got %b want 0", frame_done); end
        @(negedge clk);
        start_scan();
        n_checks++; if (bcd_out !== 4'h8) begin n_fail++; $display("FAIL drop applied d0 bcd: got %h want 8", bcd_out); end
        n_checks++; if (dig_en_n !== 4'b1110) begin n_fail++; $display("FAIL drop applied d0 en: got %b want 1110", dig_en_n); end
        repeat (15) @(negedge clk);
        n_checks++; if (bcd_out !== 4'h5) begin n_fail++; $display("FAIL drop applied d3 bcd: got %h want 5", bcd_out); end
        n_checks++; if (dig_en_n !== 4'b0111) begin n_fail++; $display("FAIL drop applied d3 en: got %b want 0111", dig_en_n); end
        enable = 1'b0;
        @(negedge clk);
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL idle write ready_before: got %b want 1", wr_ready); end
        write_word(16'h9012);
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL idle write ready_after: got %b want 1", wr_ready); end
        start_scan();
        n_checks++; if (bcd_out !== 4'h2) begin n_fail++; $display("FAIL idle write d0 bcd: got %h want 2", bcd_out); end
        repeat (5) @(negedge clk);
        n_checks++; if (bcd_out !== 4'h1) begin n_fail++; $display("FAIL idle write d1 bcd: got %h want 1", bcd_out); end
        n_checks++; if (dig_en_n !== 4'b1101) begin n_fail++; $display("FAIL idle write d1 en: got %b want 1101", dig_en_n); end
        repeat (10) @(negedge clk);
        n_checks++; if (bcd_out !== 4'h9) begin n_fail++; $display("FAIL idle write d3 bcd: got %h want 9", bcd_out); end
        n_checks++; if (dig_en_n !== 4'b0111) begin n_fail++; $display("FAIL idle write d3 en: got %b want 0111", dig_en_n); end
        $display("enable drop: pending 5678 applied, idle write 9012 applied");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_update();
        test_lz_blank();
        test_invalid();
        test_reset_mid();
        test_enable_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
